// File: rtl/regfile_clr.sv
// Operand register bank for the 16-bit ALU: two async read ports, one sync write port,
// registered zero flag, and a one-register-per-cycle clear engine started by reset.
module regfile_clr #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              zero_in,
    input  logic              z_we,
    output logic              z_flag,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] clr_ptr_next;
    logic              busy_next;
    logic              wr_en;
    logic              z_en;
    logic              byp1;
    logic              byp2;
    logic [DATA_W-1:0] regs [DEPTH];

    assign wr_en = (state == RUN) && we3 && (wa3 != '0);
    assign z_en  = (state == RUN) && z_we;

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        busy_next    = busy;
        case (state)
            CLEAR: begin
                clr_ptr_next = clr_ptr + ADDR_W'(1);
                // The last register is cleared on the same edge that hands over to RUN.
                if (&clr_ptr) begin
                    state_next = RUN;
                    busy_next  = 1'b0;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
            z_flag  <= 1'b0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
            busy    <= busy_next;
            if (z_en) begin
                z_flag <= zero_in;
            end
        end
    end

    // Data storage carries no reset; the clear engine is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_ptr] <= '0;
        end else if (wr_en) begin
            regs[wa3] <= wd3;
        end
    end

    assign byp1 = (BYPASS != 0) && wr_en && (ra1 == wa3);
    assign byp2 = (BYPASS != 0) && wr_en && (ra2 == wa3);

    assign rd1 = (busy || ra1 == '0) ? '0 : (byp1 ? wd3 : regs[ra1]);
    assign rd2 = (busy || ra2 == '0) ? '0 : (byp2 ? wd3 : regs[ra2]);

endmodule

// File: tb/tb_regfile_clr.sv
// Randomized bench for regfile_clr: write-through and plain instances share all inputs
// and are compared every cycle against an array-based reference model.
module tb_regfile_clr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ra1, ra2, wa3;
    logic        we3, zero_in, z_we;
    logic [15:0] wd3;
    logic [15:0] rd1, rd2, rd1_nb, rd2_nb;
    logic        z_flag, busy, z_flag_nb, busy_nb;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [15:0] m_reg [16];
    logic        m_busy;
    int          m_left;
    logic        m_z;
    logic        m_valid = 1'b0;

    always #5 clk = ~clk;

    regfile_clr #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) u_dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .zero_in(zero_in), .z_we(z_we),
        .z_flag(z_flag), .busy(busy)
    );

    regfile_clr #(.DATA_W(16), .ADDR_W(4), .BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .we3(we3), .wa3(wa3), .wd3(wd3), .zero_in(zero_in), .z_we(z_we),
        .z_flag(z_flag_nb), .busy(busy_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [3:0] ra, input bit byp);
        if (m_busy || ra == 4'd0) return 16'h0000;
        if (byp && we3 && wa3 != 4'd0 && wa3 == ra) return wd3;
        return m_reg[ra];
    endfunction

    task automatic check_outputs();
        chk("busy",   {31'd0, busy},    {31'd0, m_busy});
        chk("busy_nb",{31'd0, busy_nb}, {31'd0, m_busy});
        chk("z_flag", {31'd0, z_flag},  {31'd0, m_z});
        chk("z_nb",   {31'd0, z_flag_nb}, {31'd0, m_z});
        chk("rd1",    {16'd0, rd1},     {16'd0, exp_rd(ra1, 1'b1)});
        chk("rd2",    {16'd0, rd2},     {16'd0, exp_rd(ra2, 1'b1)});
        chk("rd1_nb", {16'd0, rd1_nb},  {16'd0, exp_rd(ra1, 1'b0)});
        chk("rd2_nb", {16'd0, rd2_nb},  {16'd0, exp_rd(ra2, 1'b0)});
    endtask

    // One clock: check combinational outputs with the current inputs, then advance the model.
    task automatic cycle();
        #1;
        if (m_valid) check_outputs();
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b1;
            m_left  = 16;
            m_z     = 1'b0;
            for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        end else if (m_valid && m_busy) begin
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end else if (m_valid) begin
            if (we3 && wa3 != 4'd0) m_reg[wa3] = wd3;
            if (z_we) m_z = zero_in;
        end
        #1;
    endtask

    task automatic wait_clear(input string tag);
        int cnt = 0;
        while (busy && cnt < 40) begin
            cycle();
            cnt++;
        end
        chk(tag, cnt, 32'd16);
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        we3 = 1'b1; wa3 = a; wd3 = d;
        cycle();
        we3 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ra1 = '0; ra2 = '0; wa3 = '0; we3 = 1'b0;
        wd3 = '0; zero_in = 1'b0; z_we = 1'b0;

        // 1: single reset cycle, clear takes 16 cycles
        cycle();
        reset = 1'b0;
        wait_clear("clr_len_1");
        for (int a = 0; a < 16; a++) begin
            ra1 = 4'(a); ra2 = 4'(15 - a);
            cycle();
        end

        // 2: write-through vs plain read
        we3 = 1'b1; wa3 = 4'd5; wd3 = 16'hBEEF; ra1 = 4'd5;
        #1;
        chk("byp_same", {16'd0, rd1}, 32'h0000BEEF);
        chk("nobyp_same", {16'd0, rd1_nb}, 32'h0);
        cycle();
        we3 = 1'b0;
        cycle();
        chk("after_wr", {16'd0, rd1}, 32'h0000BEEF);

        // 3: register 0 hardwired
        we3 = 1'b1; wa3 = 4'd0; wd3 = 16'h1234; ra1 = 4'd0; ra2 = 4'd0;
        #1;
        chk("r0_byp", {16'd0, rd1}, 32'h0);
        cycle();
        we3 = 1'b0;
        cycle();
        chk("r0_after", {16'd0, rd2}, 32'h0);

        // 4: two ports simultaneously, ALU a-b
        write(4'd3, 16'h00FF);
        write(4'd7, 16'hFF00);
        ra1 = 4'd3; ra2 = 4'd7;
        cycle();
        chk("alu_sub", {16'd0, 16'(rd1 - rd2)}, 32'h000001FF);

        // 5: zero flag capture and hold
        z_we = 1'b1; zero_in = 1'b1;
        cycle();
        z_we = 1'b0; zero_in = 1'b0;
        cycle();
        cycle();
        chk("z_hold", {31'd0, z_flag}, 32'd1);

        // 6: reset, partial clear, reset again
        write(4'd9, 16'hAAAA);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle(); cycle();
        we3 = 1'b1; wa3 = 4'd9; wd3 = 16'h5555;
        cycle();
        we3 = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        chk("z_reset", {31'd0, z_flag}, 32'd0);
        reset = 1'b0;
        wait_clear("clr_len_2");
        ra1 = 4'd9;
        cycle();
        chk("r9_cleared", {16'd0, rd1}, 32'h0);

        // randomized traffic, occasional reset
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            we3     = $urandom_range(0, 1) == 1;
            wa3     = 4'($urandom_range(0, 15));
            wd3     = 16'($urandom);
            ra1     = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
            ra2     = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
            z_we    = $urandom_range(0, 3) == 0;
            zero_in = $urandom_range(0, 1) == 1;
            cycle();
        end
        reset = 1'b0; we3 = 1'b0; z_we = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
